load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sits between the single-cycle core's execute stage and `dataMemory`.
- Converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses on the registered, word-addressed data memory.
- Performs read-modify-write for sub-word stores, and lane extraction plus sign/zero extension for loads.
- Flags misaligned and out-of-range accesses without touching memory; stalls the core through a valid/ready handshake.

Parameters:
- ADDR_W, 10, word-address width of data memory (1024 words, 4 KB)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; sampled on rising clk
- req_valid  in  1  core presents a memory op
- req_ready  out  1  LSU idle, accepts a request this cycle
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (size/unsigned)
- req_addr  in  32  byte address from ALU
- req_wdata  in  32  store data from rs2
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  valid with rsp_valid; misaligned/illegal/out-of-range
- rsp_rdata  out  32  extended load result; valid with rsp_valid on a non-error load
- mem_read  out  1  to dataMemory memRead
- mem_write  out  1  to dataMemory memWrite
- mem_addr  out  ADDR_W  word index, req_addr[ADDR_W+1:2]
- mem_wdata  out  32  to dataMemory writeData
- mem_rdata  in  32  from dataMemory readData; registered, valid the cycle after mem_read

Behaviour:
- States:
  - IDLE: req_ready=1.
  - RD: mem_read=1.
  - WR: mem_write=1.
  - RSP: rsp_valid=1.
- Accept: req_valid && req_ready at a rising edge latches store, funct3, addr, wdata.
- Error check at accept; an error goes IDLE->RSP with rsp_err=1 and no memory access. Error conditions:
  - Load funct3 not in {000,001,010,100,101}.
  - Store funct3 not in {000,001,010}.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - addr[31:ADDR_W+2] != 0.
- State sequences:
  - Load: IDLE->RD->RSP->IDLE. rsp_valid is high 2 cycles after the accept edge; rsp_rdata is derived from mem_rdata in RSP.
  - SW: IDLE->WR->RSP->IDLE. mem_wdata = latched wdata.
  - SB/SH: IDLE->RD->WR->RSP->IDLE. In WR, mem_wdata is mem_rdata with the addressed lane(s) replaced by wdata[7:0] (lane addr[1:0]) or wdata[15:0] (lane addr[1]); other bytes are preserved.
- Load extraction:
  - Byte lane = addr[1:0], halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- rsp_rdata = 0 outside RSP, on errors and on stores. mem_addr and mem_wdata are don't-care when read/write are low, but driven from latched registers.
- req_ready=0 in RD, WR and RSP; req_valid there is ignored and not latched. A new request can be accepted the cycle after RSP.
- Reset:
  - Next edge goes to IDLE; latched fields and rsp_err are cleared.
  - mem_read and mem_write are gated low while reset=1, so an aborted RMW never writes.
  - All outputs are 0 after reset except req_ready=1.
- rsp_valid is exactly one cycle per accepted request; there is no back-pressure on responses.

Decomposition:
- lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding S_IDLE, S_RD, S_WR, S_RSP (2 bits).
  - Helper function is_misaligned.
- One natural combinational sub-module, lsu_lane_align, performs:
  - load extract/extend (word, funct3, addr[1:0]) -> 32b.
  - store merge (old word, wdata, funct3, addr[1:0]) -> 32b.
- The FSM stays in load_store_unit.

Test Plan:
- Reset with mem_rdata=0xDEADBEEF held -> req_ready=1; rsp_valid=0, mem_read=0, mem_write=0, rsp_rdata=0.
- SW addr 0x10, wdata 0xA1B2C3D4 -> mem_write=1 with mem_addr=4 and mem_wdata=0xA1B2C3D4 one cycle after accept; rsp_valid next cycle with err=0.
- SB addr 0x11, wdata 0x000000EE, word 4 = 0xA1B2C3D4 -> RD then WR with mem_wdata=0xA1B2EED4; rsp_valid after WR; req_ready low for 3 cycles.
- Loads from word 4 = 0xA1B2EED4 (check rsp_rdata):
  - LB 0x11 -> 0xFFFFFFEE.
  - LBU 0x11 -> 0x000000EE.
  - LH 0x12 -> 0xFFFFA1B2.
  - LHU 0x12 -> 0x0000A1B2.
  - Each response comes 2 cycles after accept.
- LW 0x13, SH 0x01, and LW 0x00001000 (ADDR_W=10) -> each gives rsp_valid=1 and rsp_err=1 the cycle after accept; mem_read=0 and mem_write=0 throughout.
- SH issued, then reset asserted during WR -> mem_write stays 0 that cycle; IDLE after the edge; memory word unchanged on read-back.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 size codes,
// FSM state encoding and access-legality helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RD   = 2'b01,
      S_WR   = 2'b10,
      S_RSP  = 2'b11
   } state_t;

   // Halfwords need an even address, words a multiple of four.
   function automatic logic is_misaligned(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      case (funct3)
         F3_H, F3_HU: mis = addr_lo[0];
         F3_W:        mis = |addr_lo;
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Stores only come in signed sizes; loads add the two unsigned forms.
   function automatic logic is_illegal_f3(input logic       store,
                                          input logic [2:0] funct3);
      logic bad;
      if (store)
         bad = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
      else
         bad = !(funct3 == F3_B  || funct3 == F3_H || funct3 == F3_W ||
                 funct3 == F3_BU || funct3 == F3_HU);
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between the 32-bit memory word and the core.
// Ports:
//   i_funct3  - access size / signedness
//   i_addr_lo - byte offset within the word
//   i_word    - word read from data memory
//   i_wdata   - store data from rs2
//   o_load    - extracted and extended load value
//   o_store   - i_word with the addressed lane(s) replaced by store data
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load,
   output logic [31:0] o_store
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Load: pick lane, then sign- or zero-extend.
   always_comb begin
      w_byte = i_word[7:0];
      case (i_addr_lo)
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         2'd3:    w_byte = i_word[31:24];
         default: w_byte = i_word[7:0];
      endcase
      w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
      o_load = 32'd0;
      case (i_funct3)
         F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
         F3_H:    o_load = {{16{w_half[15]}}, w_half};
         F3_W:    o_load = i_word;
         F3_BU:   o_load = {24'd0, w_byte};
         F3_HU:   o_load = {16'd0, w_half};
         default: o_load = 32'd0;
      endcase
   end

   // Store: overlay the addressed lane(s) on the old word.
   always_comb begin
      o_store = i_word;
      case (i_funct3)
         F3_B: begin
            case (i_addr_lo)
               2'd0: o_store[7:0]   = i_wdata[7:0];
               2'd1: o_store[15:8]  = i_wdata[7:0];
               2'd2: o_store[23:16] = i_wdata[7:0];
               2'd3: o_store[31:24] = i_wdata[7:0];
               default: o_store = i_word;
            endcase
         end
         F3_H: begin
            if (i_addr_lo[1]) o_store[31:16] = i_wdata[15:0];
            else              o_store[15:0]  = i_wdata[15:0];
         end
         F3_W:    o_store = i_wdata;
         default: o_store = i_word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a registered,
// word-addressed data memory. Sub-word stores are done as read-modify-write.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   req_valid/req_ready           - request handshake from the core
//   req_store/funct3/addr/wdata   - request fields
//   rsp_valid/rsp_err/rsp_rdata   - one-cycle completion
//   mem_read/write/addr/wdata     - to data memory
//   mem_rdata                     - from data memory, valid cycle after mem_read
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [31:0]       rsp_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned BA_W = ADDR_W + 2;

   state_t           r_state;
   state_t           w_next;
   logic             r_store;
   logic [2:0]       r_funct3;
   logic [BA_W-1:0]  r_addr;
   logic [31:0]      r_wdata;
   logic             r_err;

   logic             w_err;
   logic             w_rd;
   logic             w_wr;
   logic [31:0]      w_load;
   logic [31:0]      w_store;

   // Legality is judged on the raw request so errors never reach memory.
   assign w_err = is_illegal_f3(req_store, req_funct3)
                | is_misaligned(req_funct3, req_addr[1:0])
                | (|req_addr[31:BA_W]);

   // State and latched request fields.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_store  <= 1'b0;
         r_funct3 <= 3'd0;
         r_addr   <= '0;
         r_wdata  <= 32'd0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && req_valid) begin
            r_store  <= req_store;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr[BA_W-1:0];
            r_wdata  <= req_wdata;
            r_err    <= w_err;
         end
      end
   end

   // Next state and handshake outputs.
   always_comb begin
      w_next    = r_state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      w_rd      = 1'b0;
      w_wr      = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (w_err)                               w_next = S_RSP;
               else if (req_store && req_funct3 == F3_W) w_next = S_WR;
               else                                     w_next = S_RD;
            end
         end
         S_RD: begin
            w_rd   = 1'b1;
            w_next = r_store ? S_WR : S_RSP;
         end
         S_WR: begin
            w_wr   = 1'b1;
            w_next = S_RSP;
         end
         S_RSP: begin
            rsp_valid = 1'b1;
            w_next    = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   lsu_lane_align u_align (
      .i_funct3  (r_funct3),
      .i_addr_lo (r_addr[1:0]),
      .i_word    (mem_rdata),
      .i_wdata   (r_wdata),
      .o_load    (w_load),
      .o_store   (w_store)
   );

   // Strobes are killed by reset so an interrupted read-modify-write never lands.
   assign mem_read  = w_rd & ~reset;
   assign mem_write = w_wr & ~reset;
   assign mem_addr  = r_addr[BA_W-1:2];
   assign mem_wdata = w_store;
   assign rsp_err   = rsp_valid & r_err;
   assign rsp_rdata = (rsp_valid && !r_store && !r_err) ? w_load : 32'd0;

endmodule
